// File: rtl/arb_pkg.sv
// Shared helpers for arbiters: index-width function used to size id and pointer types.
package arb_pkg;

    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority search: first valid requester at or after ptr, wrapping.
// Purely combinational; grant is one-hot, idx is its index, any_valid flags a winner.
module rr_priority_picker
    import arb_pkg::*;
#(
    parameter int n_req = 4,
    parameter int ID_W  = clog2_min1(n_req)
) (
    input  logic [n_req-1:0] i_req_valid,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [n_req-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any_valid
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_idx       = '0;
        o_any_valid = 1'b0;
        w_sum       = '0;
        w_cand      = '0;
        for (int k = 0; k < n_req; k++) begin
            // One extra bit holds ptr+k before folding back into 0..n_req-1.
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(n_req))
                w_sum = w_sum - (ID_W+1)'(n_req);
            w_cand = w_sum[ID_W-1:0];
            if (!o_any_valid && i_req_valid[w_cand]) begin
                o_any_valid     = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with bounded bursts feeding a one-entry registered output tagged with source id.
// Latency one cycle from upstream handshake; full throughput; req_ready all low while output stalls.
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter int width     = 8,
    parameter int n_req     = 4,
    parameter int max_burst = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [n_req-1:0]         req_valid,
    output logic [n_req-1:0]         req_ready,
    input  logic [n_req*width-1:0]   req_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [width-1:0]         out_data,
    output logic [$clog2(n_req)-1:0] out_id
);

    localparam int ID_W  = clog2_min1(n_req);
    localparam int CNT_W = clog2_min1(max_burst + 1);
    typedef logic [ID_W-1:0] id_t;

    logic [n_req-1:0] w_grant;
    id_t              w_win;
    logic             w_any;
    logic             w_load_en;
    logic             w_xfer;
    logic [width-1:0] w_din;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_nxt;
    id_t              w_ptr_nxt;

    id_t              r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [width-1:0] r_out_data;
    id_t              r_out_id;

    rr_priority_picker #(
        .n_req (n_req),
        .ID_W  (ID_W)
    ) u_picker (
        .i_req_valid (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_idx       (w_win),
        .o_any_valid (w_any)
    );

    assign w_load_en = !r_out_valid | out_ready;
    assign req_ready = w_grant & {n_req{w_load_en}};
    assign w_xfer    = w_any & w_load_en;

    always_comb begin
        w_din = '0;
        for (int i = 0; i < n_req; i++)
            if (w_grant[i])
                w_din = req_data[i*width +: width];
    end

    // A win away from ptr starts a new burst; an exhausted burst hands priority to the next index.
    always_comb begin
        w_cnt_inc = (w_win == r_ptr) ? r_cnt + CNT_W'(1) : CNT_W'(1);
        w_cnt_nxt = w_cnt_inc;
        w_ptr_nxt = w_win;
        if (w_cnt_inc == CNT_W'(max_burst)) begin
            w_cnt_nxt = '0;
            w_ptr_nxt = (w_win == id_t'(n_req - 1)) ? '0 : w_win + id_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
        end else if (w_xfer) begin
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= 1'b1;
            r_out_data  <= w_din;
            r_out_id    <= w_win;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scoreboarded bench: stimulus pushes model-predicted words, a monitor pops them on output handshakes.
module tb_rr_burst_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_data;
    logic           out_valid, out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;

    logic [2:0]     rv2, rr2;
    logic [3*W-1:0] rd2;
    logic           ov2, ordy2;
    logic [W-1:0]   od2;
    logic [1:0]     oid2;

    rr_burst_arbiter #(.width(W), .n_req(N), .max_burst(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id)
    );

    rr_burst_arbiter #(.width(W), .n_req(3), .max_burst(1)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(rv2), .req_ready(rr2), .req_data(rd2),
        .out_valid(ov2), .out_ready(ordy2),
        .out_data(od2), .out_id(oid2)
    );

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] dat;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errs = 0;
    int   checks = 0;
    int   m_ptr = 0;
    int   m_cnt = 0;
    bit   mon_en = 0;
    logic [N*W-1:0] fixd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan requesters starting at the priority index, wrapping around.
    function automatic int winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic [N*W-1:0] d);
        int w;
        bit le;
        logic [N-1:0] er;
        exp_t e;
        @(negedge clk);
        req_valid = v;
        out_ready = rdy;
        req_data  = d;
        #1;
        le = (q.size() == 0) || rdy;
        w  = winner(v);
        er = '0;
        if (le && w >= 0) er[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        #2;
        if (le && w >= 0) begin
            e.id  = 2'(w);
            e.dat = d[w*W +: W];
            q.push_back(e);
            if (w == m_ptr) m_cnt = m_cnt + 1;
            else            m_cnt = 1;
            if (m_cnt == MB) begin
                m_ptr = (w + 1) % N;
                m_cnt = 0;
            end else begin
                m_ptr = w;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
                if (out_valid && q.size() != 0) begin
                    mon_e = q[0];
                    chk("out_id", 32'(out_id), 32'(mon_e.id));
                    chk("out_data", 32'(out_data), 32'(mon_e.dat));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        fixd      = 32'h13121110;
        rd2       = 24'h222120;
        rv2       = 3'b111;
        ordy2     = 1'b1;
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        req_data  = '0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_id", 32'(out_id), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        #1;
        rst    = 1'b0;
        mon_en = 1;

        repeat (20) cycle(4'b1111, 1'b1, fixd);
        repeat (16) cycle(4'b0101, 1'b1, fixd);

        cycle(4'b1111, 1'b1, fixd);
        repeat (3) cycle(4'b1111, 1'b0, fixd);
        repeat (4) cycle(4'b1111, 1'b1, fixd);

        // Asynchronous reset between edges while a word is buffered.
        cycle(4'b1111, 1'b1, fixd);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_id", 32'(out_id), 0);
        chk("arst_out_data", 32'(out_data), 0);
        q.delete();
        m_ptr = 0;
        m_cnt = 0;
        #1;
        rst = 1'b0;

        repeat (4) cycle(4'b1111, 1'b1, fixd);
        repeat (2) cycle(4'b0010, 1'b1, fixd);
        repeat (4) cycle(4'b1000, 1'b1, fixd);
        repeat (6) cycle(4'b1010, 1'b1, fixd);

        repeat (1500) cycle(N'($urandom), ($urandom_range(0, 3) != 0), $urandom);

        repeat (3) cycle(4'b0000, 1'b1, '0);
        chk("drained", 32'(q.size()), 0);

        // Pure round-robin instance: reset it, then watch three-way rotation.
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #2;
            chk("rr1_valid", 32'(ov2), 1);
            chk("rr1_id", 32'(oid2), 32'(k % 3));
            chk("rr1_data", 32'(od2), 32'(8'h20 + k % 3));
            chk("rr1_ready", 32'(rr2), 32'(1 << ((k + 1) % 3)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
